// File: rtl/ddio_out_pkg.sv
// Shared helpers for the DDR output register: rising-edge action
// decode and per-bit next-state selection.
package ddio_out_pkg;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_CLR,
        ACT_SET,
        ACT_LOAD,
        ACT_HOLD
    } pos_act_t;

    function automatic pos_act_t pos_action(
        input logic reset,
        input logic sclr,
        input logic sset,
        input logic en
    );
        pos_act_t a;
        a = ACT_HOLD;
        priority case (1'b1)
            reset:   a = ACT_RESET;
            sclr:    a = ACT_CLR;
            sset:    a = ACT_SET;
            en:      a = ACT_LOAD;
            default: a = ACT_HOLD;
        endcase
        return a;
    endfunction

    function automatic logic next_bit(
        input pos_act_t a,
        input logic     pwr,
        input logic     din,
        input logic     q
    );
        logic n;
        n = q;
        case (a)
            ACT_RESET: n = pwr;
            ACT_CLR:   n = 1'b0;
            ACT_SET:   n = 1'b1;
            ACT_LOAD:  n = din;
            default:   n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ddio_out_lane.sv
// One DDR lane: high/low data registers, falling-edge retime of the
// low datum, and the clock-phase output mux.
module ddio_out_lane
    import ddio_out_pkg::*;
#(
    parameter bit POWER_UP_HIGH = 1'b0,
    parameter bit INVERT_OUTPUT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic datain_h,
    input  logic datain_l,
    input  logic outclocken,
    input  logic sclr,
    input  logic sset,
    output logic d
);

    pos_act_t act;

    logic reg_h     = POWER_UP_HIGH;
    logic reg_l_pos = POWER_UP_HIGH;
    logic reg_l_neg = POWER_UP_HIGH;

    assign act = pos_action(reset, sclr, sset, outclocken);

    always_ff @(posedge clk) begin
        reg_h     <= next_bit(act, POWER_UP_HIGH, datain_h, reg_h);
        reg_l_pos <= next_bit(act, POWER_UP_HIGH, datain_l, reg_l_pos);
    end

    // Low datum is re-timed so it only reaches the pin in the low phase.
    always_ff @(negedge clk) begin
        if (outclocken) begin
            reg_l_neg <= reg_l_pos;
        end
    end

    assign d = (clk ? reg_h : reg_l_neg) ^ INVERT_OUTPUT;

endmodule

// File: rtl/ddio_out.sv
// Vendor-neutral DDR output register with optional registered and
// disable-extended output enable driving a tri-state pin.
module ddio_out
    import ddio_out_pkg::*;
#(
    parameter int WIDTH             = 1,
    parameter bit POWER_UP_HIGH     = 1'b0,
    parameter bit INVERT_OUTPUT     = 1'b0,
    parameter bit OE_REG            = 1'b0,
    parameter bit EXTEND_OE_DISABLE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain_h,
    input  logic [WIDTH-1:0] datain_l,
    input  logic             outclocken,
    input  logic             oe,
    input  logic             sclr,
    input  logic             sset,
    output logic [WIDTH-1:0] dataout
);

    logic [WIDTH-1:0] d;
    pos_act_t         oe_act;
    logic             oe_pos = 1'b0;
    logic             oe_neg = 1'b0;
    logic             oe_eff;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ddio_out_lane #(
            .POWER_UP_HIGH(POWER_UP_HIGH),
            .INVERT_OUTPUT(INVERT_OUTPUT)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .datain_h  (datain_h[i]),
            .datain_l  (datain_l[i]),
            .outclocken(outclocken),
            .sclr      (sclr),
            .sset      (sset),
            .d         (d[i])
        );
    end

    // Enable ignores sclr/sset: only reset and the clock enable apply.
    assign oe_act = pos_action(reset, 1'b0, 1'b0, outclocken);

    always_ff @(posedge clk) begin
        oe_pos <= next_bit(oe_act, 1'b0, oe, oe_pos);
    end

    always_ff @(negedge clk) begin
        if (outclocken) begin
            oe_neg <= oe_pos;
        end
    end

    assign oe_eff = OE_REG
                  ? (oe_pos & (oe_neg | ~EXTEND_OE_DISABLE))
                  : oe;

    assign dataout = oe_eff ? d : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ddio_out.sv
// Directed bench for ddio_out across several parameter sets; pins are
// pulled up so a released output reads as all ones.
module tb_ddio_out;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_h;
    logic [7:0] din_l;
    logic       ocen;
    logic       oe;
    logic       sclr;
    logic       sset;

    wire  [7:0] dout_a;
    wire  [7:0] dout_b;
    wire  [7:0] dout_c;
    wire  [7:0] dout_e;
    wire        dout_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pullup (dout_d);
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (dout_a[i]);
        pullup (dout_b[i]);
        pullup (dout_c[i]);
        pullup (dout_e[i]);
    end

    ddio_out #(.WIDTH(8)) u_a (
        .clk(clk), .reset(reset), .datain_h(din_h), .datain_l(din_l),
        .outclocken(ocen), .oe(oe), .sclr(sclr), .sset(sset),
        .dataout(dout_a)
    );

    ddio_out #(
        .WIDTH(8), .POWER_UP_HIGH(1'b1),
        .OE_REG(1'b1), .EXTEND_OE_DISABLE(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .datain_h(din_h), .datain_l(din_l),
        .outclocken(ocen), .oe(oe), .sclr(sclr), .sset(sset),
        .dataout(dout_b)
    );

    ddio_out #(
        .WIDTH(8), .INVERT_OUTPUT(1'b1), .OE_REG(1'b1)
    ) u_c (
        .clk(clk), .reset(reset), .datain_h(din_h), .datain_l(din_l),
        .outclocken(ocen), .oe(oe), .sclr(sclr), .sset(sset),
        .dataout(dout_c)
    );

    ddio_out #(.WIDTH(1)) u_d (
        .clk(clk), .reset(reset), .datain_h(din_h[0]),
        .datain_l(din_l[0]), .outclocken(ocen), .oe(oe),
        .sclr(sclr), .sset(sset), .dataout(dout_d)
    );

    ddio_out #(.WIDTH(8), .POWER_UP_HIGH(1'b1)) u_e (
        .clk(clk), .reset(reset), .datain_h(din_h), .datain_l(din_l),
        .outclocken(ocen), .oe(oe), .sclr(sclr), .sset(sset),
        .dataout(dout_e)
    );

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic hi();
        @(posedge clk);
        #2;
    endtask

    task automatic lo();
        @(negedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        din_h = 8'h00;
        din_l = 8'h00;
        ocen  = 1'b1;
        oe    = 1'b1;
        sclr  = 1'b0;
        sset  = 1'b0;

        hi();
        check("rst_a_h", dout_a, 8'h00);
        check("rst_d_h", {7'd0, dout_d}, 8'h00);
        lo();
        check("rst_a_l", dout_a, 8'h00);

        reset = 1'b0;
        din_l = 8'hFF;
        hi();
        check("clk1_d_h", {7'd0, dout_d}, 8'h00);
        lo();
        check("clk1_d_l", {7'd0, dout_d}, 8'h01);
        check("clk1_c_l", dout_c, 8'h00);
        hi();
        check("clk2_d_h", {7'd0, dout_d}, 8'h00);
        check("clk2_b_h", dout_b, 8'h00);
        lo();
        check("clk2_d_l", {7'd0, dout_d}, 8'h01);
        check("clk2_b_l", dout_b, 8'hFF);

        din_h = 8'hA5;
        din_l = 8'h3C;
        hi();
        check("pat_a_h", dout_a, 8'hA5);
        check("pat_b_h", dout_b, 8'hA5);
        check("pat_c_h", dout_c, 8'h5A);
        lo();
        check("pat_a_l", dout_a, 8'h3C);
        check("pat_c_l", dout_c, 8'hC3);

        din_h = 8'h0F;
        din_l = 8'hF0;
        hi();
        check("inv_c_h", dout_c, 8'hF0);
        check("inv_a_h", dout_a, 8'h0F);
        lo();
        check("inv_c_l", dout_c, 8'h0F);
        check("inv_a_l", dout_a, 8'hF0);

        reset = 1'b1;
        din_h = 8'h00;
        din_l = 8'h00;
        hi();
        check("pwr1_e_h", dout_e, 8'hFF);
        check("pwr0_a_h", dout_a, 8'h00);
        lo();
        check("pwr1_e_l", dout_e, 8'hFF);

        reset = 1'b0;
        hi();
        check("rel_e_h", dout_e, 8'h00);
        lo();
        check("rel_e_l", dout_e, 8'h00);

        sclr  = 1'b1;
        sset  = 1'b1;
        din_h = 8'hA5;
        din_l = 8'h3C;
        hi();
        check("clrset_a_h", dout_a, 8'h00);
        check("clrset_e_h", dout_e, 8'h00);
        lo();
        check("clrset_a_l", dout_a, 8'h00);

        sclr = 1'b0;
        hi();
        check("set_a_h", dout_a, 8'hFF);
        lo();
        check("set_a_l", dout_a, 8'hFF);

        sset  = 1'b0;
        din_h = 8'h12;
        din_l = 8'h34;
        hi();
        check("ld_a_h", dout_a, 8'h12);
        lo();
        check("ld_a_l", dout_a, 8'h34);

        ocen  = 1'b0;
        din_h = 8'h56;
        din_l = 8'h78;
        hi();
        check("hold_a_h", dout_a, 8'h12);
        lo();
        check("hold_a_l", dout_a, 8'h34);
        check("hold_b_l", dout_b, 8'h34);

        ocen  = 1'b1;
        din_h = 8'h0F;
        din_l = 8'h0F;
        oe    = 1'b0;
        #1;
        check("oe0_a_now", dout_a, 8'hFF);
        hi();
        check("oe0_a_h", dout_a, 8'hFF);
        check("oe0_b_h", dout_b, 8'hFF);
        check("oe0_c_h", dout_c, 8'hFF);
        lo();
        check("oe0_b_l", dout_b, 8'hFF);
        check("oe0_c_l", dout_c, 8'hFF);

        oe = 1'b1;
        #1;
        check("oe1_a_now", dout_a, 8'h0F);
        hi();
        check("oe1_b_h", dout_b, 8'hFF);
        check("oe1_c_h", dout_c, 8'hF0);
        lo();
        check("oe1_b_l", dout_b, 8'h0F);
        check("oe1_c_l", dout_c, 8'hF0);
        hi();
        check("oe2_b_h", dout_b, 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
